// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and load scoreboard for the 8-bit register file.
// Shares the single RF write port between the ALU and load-return paths,
// and tracks registers with an outstanding load so issue can stall on
// read-after-load / write-after-load hazards.
module rf_wb_arbiter #(
  parameter int DW         = 8,
  parameter int AW         = 5,
  parameter int NREG       = 9,
  parameter int STARVE_MAX = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_alu_valid,
  input  logic [AW-1:0]   i_alu_ptr,
  input  logic [DW-1:0]   i_alu_data,
  output logic            o_alu_ready,
  input  logic            i_ld_valid,
  input  logic [AW-1:0]   i_ld_ptr,
  input  logic [DW-1:0]   i_ld_data,
  output logic            o_ld_ready,
  input  logic            i_issue_valid,
  input  logic [AW-1:0]   i_issue_ptr_a,
  input  logic [AW-1:0]   i_issue_ptr_b,
  input  logic            i_issue_b_const,
  input  logic            i_issue_ld,
  input  logic [AW-1:0]   i_issue_ptr_w,
  output logic            o_stall,
  output logic            o_rf_we,
  output logic [AW-1:0]   o_rf_ptr_w,
  output logic [DW-1:0]   o_rf_di,
  output logic [NREG-1:0] o_pending,
  output logic            o_err_ptr
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  // Highest register index is the overflow register; writes to it or beyond are errors.
  localparam logic [AW-1:0] OVF_PTR = AW'(NREG - 1);

  logic [SW-1:0]   r_starve;
  logic            r_rf_we;
  logic [AW-1:0]   r_rf_ptr_w;
  logic [DW-1:0]   r_rf_di;
  logic            r_src_ld;
  logic            r_err_ptr;
  logic [NREG-1:0] r_pending;

  logic            w_starved;
  logic            w_gnt;
  logic [AW-1:0]   w_ptr;
  logic [DW-1:0]   w_data;
  logic            w_legal;
  logic            w_bad;
  logic            w_hit_a;
  logic            w_hit_b;
  logic            w_hit_w;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  // Load wins by default; a starved ALU takes the port. Readies held low in reset.
  assign w_starved   = (r_starve == SW'(STARVE_MAX));
  assign o_alu_ready = i_rst_n && i_alu_valid && (!i_ld_valid || w_starved);
  assign o_ld_ready  = i_rst_n && i_ld_valid && !(i_alu_valid && w_starved);
  assign w_gnt       = o_alu_ready || o_ld_ready;
  assign w_ptr       = o_alu_ready ? i_alu_ptr  : i_ld_ptr;
  assign w_data      = o_alu_ready ? i_alu_data : i_ld_data;
  assign w_legal     = (w_ptr != '0) && (w_ptr < OVF_PTR);
  assign w_bad       = (w_ptr >= OVF_PTR);

  // Count consecutive lost ALU arbitrations, saturating; any ALU grant or idle clears.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       r_starve <= '0;
    else if (!i_alu_valid || o_alu_ready) r_starve <= '0;
    else if (!w_starved)                r_starve <= r_starve + 1'b1;
  end

  // Write-port output register; ptr/data hold when idle, source tag kept for scoreboard clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_ptr_w <= '0;
      r_rf_di    <= '0;
      r_src_ld   <= 1'b0;
      r_err_ptr  <= 1'b0;
    end else begin
      r_rf_we   <= w_gnt && w_legal;
      r_err_ptr <= w_gnt && w_bad;
      if (w_gnt) begin
        r_rf_ptr_w <= w_ptr;
        r_rf_di    <= w_data;
        r_src_ld   <= o_ld_ready;
      end
    end
  end

  // Scoreboard lookups; pointer 0 and pointers beyond the file never hit.
  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    w_hit_w = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (i_issue_ptr_a == AW'(i) && r_pending[i]) w_hit_a = 1'b1;
      if (i_issue_ptr_b == AW'(i) && r_pending[i]) w_hit_b = 1'b1;
      if (i_issue_ptr_w == AW'(i) && r_pending[i]) w_hit_w = 1'b1;
    end
  end

  assign o_stall = i_rst_n && i_issue_valid &&
                   (w_hit_a || (!i_issue_b_const && w_hit_b) || w_hit_w);

  // Set on an accepted load issue to a writable register; clear on a committing load write.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 1; i < NREG - 1; i++)
      w_set[i] = i_issue_valid && !o_stall && i_issue_ld && (i_issue_ptr_w == AW'(i));
    for (int i = 1; i < NREG; i++)
      w_clr[i] = r_rf_we && r_src_ld && (r_rf_ptr_w == AW'(i));
  end

  // Pending bitmask; a set on the same edge as a clear wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pending <= '0;
    else          r_pending <= (r_pending & ~w_clr) | w_set;
  end

  assign o_rf_we    = r_rf_we;
  assign o_rf_ptr_w = r_rf_ptr_w;
  assign o_rf_di    = r_rf_di;
  assign o_err_ptr  = r_err_ptr;
  assign o_pending  = r_pending;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed stimulus pushes hand-computed
// write-port events; a monitor pops and compares whenever rf_we or err_ptr rises.
module tb_rf_wb_arbiter;
  localparam int DW = 8, AW = 5, NREG = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, ld_valid;
  logic [AW-1:0]   alu_ptr, ld_ptr;
  logic [DW-1:0]   alu_data, ld_data;
  logic            alu_ready, ld_ready;
  logic            issue_valid, issue_b_const, issue_ld;
  logic [AW-1:0]   issue_ptr_a, issue_ptr_b, issue_ptr_w;
  logic            stall, rf_we, err_ptr;
  logic [AW-1:0]   rf_ptr_w;
  logic [DW-1:0]   rf_di;
  logic [NREG-1:0] pending;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] ptr;
    logic [DW-1:0] di;
    logic          err;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DW(DW), .AW(AW), .NREG(NREG), .STARVE_MAX(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_valid(alu_valid), .i_alu_ptr(alu_ptr), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
    .i_ld_valid(ld_valid), .i_ld_ptr(ld_ptr), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
    .i_issue_valid(issue_valid), .i_issue_ptr_a(issue_ptr_a), .i_issue_ptr_b(issue_ptr_b),
    .i_issue_b_const(issue_b_const), .i_issue_ld(issue_ld), .i_issue_ptr_w(issue_ptr_w),
    .o_stall(stall), .o_rf_we(rf_we), .o_rf_ptr_w(rf_ptr_w), .o_rf_di(rf_di),
    .o_pending(pending), .o_err_ptr(err_ptr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [AW-1:0] p, input logic [DW-1:0] d, input logic e);
    ev_t ev;
    ev.we = we; ev.ptr = p; ev.di = d; ev.err = e;
    exp_q.push_back(ev);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_ptr = '0; alu_data = '0;
    ld_valid = 0;  ld_ptr = '0;  ld_data = '0;
    issue_valid = 0; issue_ptr_a = '0; issue_ptr_b = '0;
    issue_b_const = 0; issue_ld = 0; issue_ptr_w = '0;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic bc,
                       input logic ld, input logic [AW-1:0] w);
    issue_valid = 1; issue_ptr_a = a; issue_ptr_b = b;
    issue_b_const = bc; issue_ld = ld; issue_ptr_w = w;
  endtask

  // Monitor: every visible write-port event must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && (rf_we || err_ptr)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got we=%0b ptr=%0h di=%0h err=%0b, expected none",
                 rf_we, rf_ptr_w, rf_di, err_ptr);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (rf_we !== e.we || err_ptr !== e.err ||
            (e.we && (rf_ptr_w !== e.ptr || rf_di !== e.di))) begin
          n_fail++;
          $display("FAIL wb_event: got we=%0b ptr=%0h di=%0h err=%0b, expected we=%0b ptr=%0h di=%0h err=%0b",
                   rf_we, rf_ptr_w, rf_di, err_ptr, e.we, e.ptr, e.di, e.err);
        end
      end
    end
  end

  // Arbitration table: both valid, STARVE_MAX=3 -> ld,ld,ld,alu,ld, then lone ALU.
  logic          t_ldv  [6] = '{1, 1, 1, 1, 1, 0};
  logic [AW-1:0] t_ldp  [6] = '{1, 3, 4, 5, 5, 0};
  logic [DW-1:0] t_ldd  [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA3, 8'h00};
  logic [AW-1:0] t_alp  [6] = '{2, 2, 2, 2, 6, 6};
  logic [DW-1:0] t_ald  [6] = '{8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB1, 8'hB1};
  logic          t_ldr  [6] = '{1, 1, 1, 0, 1, 0};
  logic          t_alr  [6] = '{0, 0, 0, 1, 0, 1};

  initial begin
    idle();
    rst_n = 0;
    alu_valid = 1; ld_valid = 1; issue_valid = 1;
    nxt(); nxt();
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_outs", {rf_we, rf_ptr_w, rf_di, err_ptr, stall}, 0);
    chk("rst_pending", pending, 0);
    idle();
    rst_n = 1;
    nxt();

    // Arbitration and starvation
    for (int c = 0; c < 6; c++) begin
      ld_valid = t_ldv[c]; ld_ptr = t_ldp[c]; ld_data = t_ldd[c];
      alu_valid = 1; alu_ptr = t_alp[c]; alu_data = t_ald[c];
      #1;
      chk($sformatf("arb_ld_ready_c%0d", c), ld_ready, t_ldr[c]);
      chk($sformatf("arb_alu_ready_c%0d", c), alu_ready, t_alr[c]);
      if (t_ldr[c]) push(1, t_ldp[c], t_ldd[c], 0);
      else if (t_alr[c]) push(1, t_alp[c], t_ald[c], 0);
      nxt();
    end
    idle();
    nxt();

    // Read-after-load stall on r3
    issue(0, 0, 0, 1, 3); #1;
    chk("raw_issue_ld_stall", stall, 0);
    nxt();
    issue(3, 0, 0, 0, 0); #1;
    chk("raw_stall_a", stall, 1);
    chk("raw_pending", pending, 9'h008);
    nxt();
    ld_valid = 1; ld_ptr = 3; ld_data = 8'h5A; #1;   // cycle N
    chk("raw_ld_ready", ld_ready, 1);
    chk("raw_stall_N", stall, 1);
    push(1, 3, 8'h5A, 0);
    nxt();
    ld_valid = 0; #1;                                // N+1
    chk("raw_stall_N1", stall, 1);
    nxt();
    #1;                                              // N+2
    chk("raw_stall_N2", stall, 0);
    chk("raw_pending_clr", pending, 0);
    idle();

    // Immediate B, WAW, r0 and out-of-range pointers
    issue(0, 0, 0, 1, 3);
    nxt();
    issue(0, 3, 1, 0, 0); #1;
    chk("bconst_no_stall", stall, 0);
    issue_b_const = 0; #1;
    chk("b_reg_stall", stall, 1);
    issue(0, 0, 1, 0, 3); #1;
    chk("waw_stall", stall, 1);
    idle();
    ld_valid = 1; ld_ptr = 3; ld_data = 8'h77;
    push(1, 3, 8'h77, 0);
    nxt();
    idle();
    issue(0, 0, 0, 1, 0);                            // load to r0
    nxt();
    issue(0, 0, 0, 1, 9);                            // load to ptr 9
    nxt();
    issue(9, 9, 0, 0, 9); #1;
    chk("r0_ptr9_pending", pending, 0);
    chk("ptr9_no_stall", stall, 0);
    idle();

    // Illegal pointers
    alu_valid = 1; alu_ptr = 8; alu_data = 8'hFF; #1;
    chk("ovf_alu_ready", alu_ready, 1);
    push(0, 8, 8'hFF, 1);
    nxt();
    alu_ptr = 0; alu_data = 8'h12; #1;
    chk("ovf_we", rf_we, 0);
    chk("zero_alu_ready", alu_ready, 1);
    nxt();
    idle(); #1;
    chk("zero_no_err", {rf_we, err_ptr}, 0);
    nxt();

    // Same-edge set and clear on r5: set wins
    ld_valid = 1; ld_ptr = 5; ld_data = 8'h33;
    push(1, 5, 8'h33, 0);
    nxt();
    idle();
    issue(0, 0, 0, 1, 5); #1;
    chk("sc_issue_stall", stall, 0);
    nxt();
    idle(); #1;
    chk("sc_pending5", pending, 9'h020);
    ld_valid = 1; ld_ptr = 5; ld_data = 8'h44;
    push(1, 5, 8'h44, 0);
    nxt();
    idle();
    nxt(); #1;
    chk("sc_pending_clr", pending, 0);

    // Reset mid-stream with pending=0x0E and a grant in flight
    issue(0, 0, 0, 1, 1); nxt();
    issue(0, 0, 0, 1, 2); nxt();
    issue(0, 0, 0, 1, 3); nxt();
    idle();
    ld_valid = 1; ld_ptr = 1; ld_data = 8'h99;
    nxt();
    idle();
    chk("mid_pending", pending, 9'h00E);
    chk("mid_inflight_we", rf_we, 1);
    rst_n = 0;
    alu_valid = 1; alu_ptr = 4; ld_valid = 1; ld_ptr = 4;
    issue(1, 2, 0, 0, 3); #1;
    chk("mid_rst_outs", {rf_we, rf_ptr_w, rf_di, err_ptr, stall}, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_ready", {alu_ready, ld_ready}, 0);
    idle();
    nxt();
    rst_n = 1;
    nxt();
    alu_valid = 1; alu_ptr = 7; alu_data = 8'hC3; #1;
    chk("post_rst_alu_ready", alu_ready, 1);
    push(1, 7, 8'hC3, 0);
    nxt();
    idle();
    nxt(); nxt();
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and load scoreboard for the 8-bit register file. The register file has one write port. This block shares that port between the ALU result path and the load-return path using valid/ready handshakes. It also tracks registers with an outstanding load, so the issue stage stalls on read-after-load and write-after-load hazards. It sits between the execute/memory stages and the register file's `we`/`ptr_w`/`di` inputs.

## Interface
Parameters:
- `DW`, 8, data width
- `AW`, 5, register pointer width
- `NREG`, 9, register count; register 0 reads as zero, register 8 is the hardware overflow register
- `STARVE_MAX`, 3, consecutive lost ALU arbitrations before the ALU is forced to win

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  one clock; reset is asynchronous and active-low
- `alu_valid` in 1; `alu_ptr` in AW; `alu_data` in DW; `alu_ready` out 1. ALU write-back request.
- `ld_valid` in 1; `ld_ptr` in AW; `ld_data` in DW; `ld_ready` out 1. Load-return write-back request.
- `issue_valid`  in  1  an instruction is presented at issue
- `issue_ptr_a`  in  AW  source A pointer
- `issue_ptr_b`  in  AW  source B pointer
- `issue_b_const`  in  1  B is an immediate; `issue_ptr_b` is not checked for hazards
- `issue_ld`  in  1  the instruction is a load that writes `issue_ptr_w`
- `issue_ptr_w`  in  AW  destination pointer
- `stall`  out  1  combinational; the issue stage must hold its instruction
- `rf_we` out 1; `rf_ptr_w` out AW; `rf_di` out DW. Registered outputs that drive the register file write port.
- `pending`  out  NREG  scoreboard bitmask; bit r set means a load to r is outstanding
- `err_ptr`  out  1  registered one-cycle pulse when an accepted request had an illegal pointer

## Operation
- Handshake: a transfer occurs on a cycle where valid && ready. The requester holds valid, ptr and data stable until ready. Ready is combinational from the valids and the starve counter. Ready is never asserted without the matching valid.
- Arbitration:
  - At most one grant per cycle.
  - Default priority is load over ALU.
  - The ALU wins when `starve_cnt == STARVE_MAX` and both are valid.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on cycles with alu_valid && !alu_ready.
  - Clears on an ALU grant or when alu_valid is low.
- Legal write pointers are 1..7.
  - ptr 0: the handshake completes, rf_we stays 0, no error.
  - ptr ≥ 8: the handshake completes, rf_we stays 0, err_ptr pulses. Register 8 is owned by the overflow logic.
- Scoreboard (NREG bits):
  - Set: bit p sets on issue_valid && !stall && issue_ld, where p = issue_ptr_w and p is in 1..7.
  - Clear: bit p clears at the edge that ends a cycle with rf_we=1 and rf_ptr_w=p, and only if the write came from the load path. A 1-bit source tag is kept with the output register for this.
  - Set and clear of the same bit on the same edge: set wins.
- Stall is asserted when issue_valid and any of the following holds:
  - pending[issue_ptr_a] and issue_ptr_a ≠ 0;
  - !issue_b_const and pending[issue_ptr_b] and issue_ptr_b ≠ 0;
  - pending[issue_ptr_w] and issue_ptr_w ≠ 0 (WAW).
- Pointers ≥ NREG index no scoreboard bit and never cause a stall.
- An ALU write to a pending register is accepted and written. The later load write still lands. Ordering is the issue stage's responsibility, and the WAW stall guarantees it.

## Timing
- Reset (async assert, sync release): rf_we=0, rf_ptr_w=0, rf_di=0, err_ptr=0, pending=0, starve_cnt=0. While reset is low, alu_ready=0, ld_ready=0 and stall=0.
- Handshake in cycle N gives rf_we/rf_ptr_w/rf_di valid in N+1. The register file commits at the end of N+1.
- A load write granted in N clears its pending bit at the end of N+1. A dependent instruction stalls through N+1 and issues in N+2, when it reads the committed value.
- Back-to-back grants are allowed every cycle. With no grant in a cycle, rf_we=0 in the next cycle and rf_ptr_w/rf_di hold.
- Reset asserted mid-transfer drops the in-flight write (rf_we forced to 0) and clears all scoreboard state.

## Test plan
- Load and ALU both valid for 5 cycles, both writing legal pointers, STARVE_MAX=3: grants are ld,ld,ld,alu,ld. rf_we is high on each following cycle with the matching ptr/data.
- Issue a load to r3, then an instruction with ptr_a=3: stall=1 until ld write-back to r3 (data 0x5A) is granted in N. stall=0 in N+2, and rf_di=0x5A appeared in N+1.
- Issue with ptr_b=3, issue_b_const=1, pending[3]=1: stall=0. Same with ptr_b=0 and pending[0] forced impossible: pending stays 0 after a load issued to r0.
- ALU request to ptr 8, data 0xFF: alu_ready=1, rf_we=0 the next cycle, err_ptr pulses once. ALU request to ptr 0: no err_ptr.
- Load issue to r5 on the same cycle as load write-back to r5 commits: pending[5] remains 1.
- Assert reset low mid-stream with pending=0x0E and a grant in flight: all outputs are 0 immediately. After release, the first request is granted normally.
